// File: rtl/count_ctrl.sv
// Command-driven sequencer for the up-counter datapath: LOAD / RUN N / STOP / CLEAR
// over a valid/ready port, with busy, done, wrap and err status.
module count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_RUN   = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic             accept;
    op_t              op;

    assign op        = op_t'(cmd_op);
    assign cmd_ready = !rst && (state != ST_DONE);
    assign accept    = cmd_valid && cmd_ready;

    // Status is a pure decode of the state register, so it carries no extra latency.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // NOTE: every register here is written with <= so all updates see pre-edge values;
    // a blocking assignment would let later statements observe the new count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            remaining <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OP_LOAD:  count <= cmd_data;
                            OP_RUN: begin
                                remaining <= cmd_data;
                                state     <= (cmd_data != '0) ? ST_RUN : ST_DONE;
                            end
                            OP_STOP:  ;
                            OP_CLEAR: count <= '0;
                        endcase
                    end
                end

                ST_RUN: begin
                    if (accept && op == OP_STOP) begin
                        state <= ST_IDLE;
                    end else if (accept && op == OP_CLEAR) begin
                        count     <= '0;
                        remaining <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        // LOAD/RUN mid-run are dropped with an error; the step still happens.
                        err       <= accept;
                        wrap      <= (count == '1);
                        count     <= count + WIDTH'(1);
                        remaining <= remaining - WIDTH'(1);
                        if (remaining == WIDTH'(1))
                            state <= ST_DONE;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios followed by random commands,
// compared each cycle against a behavioural model of the command rules.
module tb_count_ctrl;

    localparam int WIDTH = 8;
    localparam int MODN  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: mode is 0 idle, 1 running, 2 done-cycle; numbers are plain ints.
    int m_mode  = 0;
    int m_count = 0;
    int m_left  = 0;
    int m_wrap  = 0;
    int m_err   = 0;

    count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void model_edge(input bit r, input bit acc, input int op, input int data);
        m_wrap = 0;
        m_err  = 0;
        if (r) begin
            m_mode = 0; m_count = 0; m_left = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (acc && op == 2) begin
                m_mode = 0;
            end else if (acc && op == 3) begin
                m_count = 0; m_left = 0; m_mode = 0;
            end else begin
                m_err   = acc ? 1 : 0;
                m_wrap  = (m_count == MODN - 1) ? 1 : 0;
                m_count = (m_count + 1) % MODN;
                m_left  = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
        end else if (acc) begin
            case (op)
                0: m_count = data;
                1: begin
                    m_left = data;
                    m_mode = (data == 0) ? 2 : 1;
                end
                3: m_count = 0;
                default: ;
            endcase
        end
    endfunction

    // One clock cycle: drive, check ready before the edge, advance model, check after it.
    task automatic step(input bit v, input int op, input int data, input bit r);
        bit exp_ready;
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_data  = WIDTH'(data);
        rst       = r;
        #1;
        exp_ready = !r && (m_mode != 2);
        check("cmd_ready", int'(cmd_ready), int'(exp_ready));
        @(posedge clk);
        model_edge(r, v && exp_ready, op, data);
        #1;
        check("count", int'(count), m_count);
        check("busy",  int'(busy),  (m_mode == 1) ? 1 : 0);
        check("done",  int'(done),  (m_mode == 2) ? 1 : 0);
        check("wrap",  int'(wrap),  m_wrap);
        check("err",   int'(err),   m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;

        // Reset behaviour, cmd_ready low while rst is high
        step(0, 0, 0, 1);
        step(1, 0, 8'h33, 1);
        idle(1);

        // LOAD 0x10, RUN 5
        step(1, 0, 8'h10, 0);
        step(1, 1, 5, 0);
        idle(7);
        check("run5_final", int'(count), 8'h15);

        // LOAD 0xFE, RUN 3 wraps through zero
        step(1, 0, 8'hFE, 0);
        step(1, 1, 3, 0);
        idle(5);
        check("wrap_final", int'(count), 8'h01);

        // RUN 10 from 0, STOP after four increments, then RUN 2
        step(1, 0, 8'h00, 0);
        step(1, 1, 10, 0);
        idle(4);
        step(1, 2, 0, 0);
        check("stop_hold", int'(count), 8'h04);
        check("stop_busy", int'(busy), 0);
        idle(2);
        step(1, 1, 2, 0);
        idle(3);
        check("rerun_final", int'(count), 8'h06);

        // LOAD during RUN raises err and is ignored; RUN 0 completes at once
        step(1, 0, 8'h20, 0);
        step(1, 1, 6, 0);
        idle(1);
        step(1, 0, 8'h55, 0);
        idle(6);
        check("err_run_final", int'(count), 8'h26);
        step(1, 1, 0, 0);
        check("run0_done", int'(done), 1);
        idle(2);

        // CLEAR mid-run, STOP in idle
        step(1, 0, 8'h80, 0);
        step(1, 1, 9, 0);
        idle(2);
        step(1, 3, 0, 0);
        step(1, 2, 0, 0);
        check("clear_mid", int'(count), 0);

        // Reset mid-run, then immediate LOAD
        step(1, 1, 8, 0);
        idle(3);
        step(0, 0, 0, 1);
        check("rst_mid_count", int'(count), 0);
        step(1, 0, 8'h77, 0);
        check("load_after_rst", int'(count), 8'h77);

        // Random commands with occasional reset
        for (int i = 0; i < 1500; i++) begin
            int  op;
            int  data;
            bit  v;
            bit  r;
            v    = ($urandom_range(0, 99) < 35);
            r    = ($urandom_range(0, 99) < 2);
            op   = int'($urandom_range(0, 3));
            data = (op == 1) ? int'($urandom_range(0, 12))
                             : (($urandom_range(0, 3) == 0) ? int'($urandom_range(MODN - 4, MODN - 1))
                                                             : int'($urandom_range(0, MODN - 1)));
            step(v, op, data, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
